// File: rtl/du.sv
// Datapath for a 4x4 shift-and-add multiplier: A shifts left, B shifts right,
// P accumulates. An external controller drives every enable from b0/z.
module du (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dataA,
  input  logic [3:0] dataB,
  input  logic       ldA,
  input  logic       ctrlA,
  input  logic       ldB,
  input  logic       ctrlB,
  input  logic       ldP,
  input  logic       Psel,
  output logic       b0,
  output logic       z,
  output logic [7:0] P
);

  logic [7:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] p_q, p_d;

  // The add reads a_q, the pre-edge A, so add and shift can share a cycle.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (ldA) a_d = ctrlA ? {4'b0000, dataA} : {a_q[6:0], 1'b0};
    if (ldB) b_d = ctrlB ? dataB : {1'b0, b_q[3:1]};
    if (ldP) p_d = Psel ? (p_q + a_q) : 8'h00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= 8'h00;
      b_q <= 4'h0;
      p_q <= 8'h00;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end

  assign b0 = b_q[0];
  assign z  = (b_q == 4'h0);
  assign P  = p_q;

endmodule

// File: tb/tb_du.sv
// Scoreboard bench for du: each scenario pushes the expected {P,b0,z} as it
// drives a cycle and pops/compares once the DUT has updated.
module tb_du;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dataA, dataB;
  logic       ldA, ctrlA, ldB, ctrlB, ldP, Psel;
  logic       b0, z;
  logic [7:0] P;

  du dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .ldA(ldA), .ctrlA(ctrlA), .ldB(ldB), .ctrlB(ctrlB),
    .ldP(ldP), .Psel(Psel), .b0(b0), .z(z), .P(P)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic       b0;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

  function automatic exp_t mk(input logic [7:0] p, input logic bb0, input logic zz);
    exp_t r;
    r.p = p; r.b0 = bb0; r.z = zz;
    return r;
  endfunction

  // Drive one set of controls, let one rising edge happen, settle 1 time unit.
  task automatic cyc(input logic la, input logic ca, input logic lb, input logic cb,
                     input logic lp, input logic ps, input logic [3:0] da, input logic [3:0] db);
    ldA = la; ctrlA = ca; ldB = lb; ctrlB = cb; ldP = lp; Psel = ps;
    dataA = da; dataB = db;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    {ldA, ctrlA, ldB, ctrlB, ldP, Psel} = '0;
    dataA = 4'h0; dataB = 4'h0;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_initial: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    @(negedge clk);
    reset = 1'b1;
    // Build nonzero state: A=5, B=3, then P=5.
    cyc(1, 1, 1, 1, 1, 0, 4'h5, 4'h3);
    cyc(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    sb.push_back(mk(8'h05, 1'b1, 1'b0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_prestate: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_async: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    // Every enable active while reset is held low.
    cyc(1, 1, 1, 1, 1, 1, 4'hF, 4'hF);
    cyc(1, 0, 1, 0, 1, 1, 4'hF, 4'hF);
    sb.push_back(mk(8'h00, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_held: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    @(negedge clk);
    reset = 1'b1;
    // A stayed cleared: an add from P=0 gives 0.
    cyc(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    sb.push_back(mk(8'h00, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_release: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
  endtask

  task automatic test_load;
    cyc(1, 1, 1, 1, 1, 0, 4'h5, 4'h3);
    sb.push_back(mk(8'h00, 1'b1, 1'b0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL load: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
  endtask

  // Runs the intended controller sequence; tr records P after each step.
  task automatic test_multiply(input logic [3:0] a, input logic [3:0] b,
                               output logic [3:0][7:0] tr, output int nsteps);
    logic [7:0] ma, mp, prod;
    logic [3:0] mb;
    logic       lp;
    tr = '0; nsteps = 0;
    ma = {4'h0, a}; mb = b; mp = 8'h00;
    prod = {4'h0, a} * {4'h0, b};
    cyc(1, 1, 1, 1, 1, 0, a, b);
    sb.push_back(mk(mp, mb[0], mb == 4'h0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL mul_load %0dx%0d: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", a, b, P, b0, z, e.p, e.b0, e.z);
    end
    for (int k = 0; k < 4 && mb != 4'h0; k++) begin
      lp = mb[0];
      if (lp) mp = mp + ma;
      ma = {ma[6:0], 1'b0};
      mb = {1'b0, mb[3:1]};
      cyc(1, 0, 1, 0, lp, 1'b1, 4'h0, 4'h0);
      sb.push_back(mk(mp, mb[0], mb == 4'h0));
      e = sb.pop_front(); total++;
      if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
        bad++;
        $display("FAIL mul_step%0d %0dx%0d: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", k, a, b, P, b0, z, e.p, e.b0, e.z);
      end
      tr[k] = P;
      nsteps++;
    end
    total++;
    if (P !== prod || z !== 1'b1) begin
      bad++;
      $display("FAIL mul_result %0dx%0d: got P=%0d z=%b want P=%0d z=1", a, b, P, z, prod);
    end
  endtask

  task automatic test_mul_5x3;
    logic [3:0][7:0] tr;
    int n;
    test_multiply(4'd5, 4'd3, tr, n);
    total++;
    if (n !== 2 || tr[0] !== 8'd5 || tr[1] !== 8'd15) begin
      bad++;
      $display("FAIL mul_5x3_trace: got n=%0d P=%0d,%0d want n=2 P=5,15", n, tr[0], tr[1]);
    end
  endtask

  task automatic test_mul_15x15;
    logic [3:0][7:0] tr;
    int n;
    test_multiply(4'd15, 4'd15, tr, n);
    total++;
    if (n !== 4 || tr[0] !== 8'd15 || tr[1] !== 8'd45 || tr[2] !== 8'd105 || tr[3] !== 8'd225) begin
      bad++;
      $display("FAIL mul_15x15_trace: got n=%0d P=%0d,%0d,%0d,%0d want n=4 P=15,45,105,225",
               n, tr[0], tr[1], tr[2], tr[3]);
    end
  endtask

  task automatic test_overflow;
    // Load A=F, B=0, clear P; shift A 5 times; add.
    cyc(1, 1, 1, 1, 1, 0, 4'hF, 4'h0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    cyc(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    sb.push_back(mk(8'hE0, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL ovf_a_shift: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    // Build P=F0, then A=20, then add to wrap.
    cyc(1, 1, 0, 0, 1, 0, 4'hF, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    cyc(1, 1, 0, 0, 1, 1, 4'h1, 4'h0);
    sb.push_back(mk(8'hF0, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL ovf_p_setup: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    cyc(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    sb.push_back(mk(8'h10, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL ovf_p_wrap: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
  endtask

  task automatic test_hold_clear;
    cyc(1, 1, 1, 1, 1, 0, 4'h3, 4'hA);
    cyc(0, 0, 0, 0, 1, 1, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 1, 4'hC, 4'h5);
    sb.push_back(mk(8'h03, 1'b0, 1'b0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL hold: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    cyc(0, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    sb.push_back(mk(8'h00, 1'b0, 1'b0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL clear_p: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    // A survived the clear (add gives 3); B survived (shift gives 5, b0=1).
    cyc(0, 0, 1, 0, 1, 1, 4'h0, 4'h0);
    sb.push_back(mk(8'h03, 1'b1, 1'b0));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL clear_keeps_ab: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0][7:0] tr;
    int n;
    test_multiply(4'd0, 4'd7, tr, n);
    test_multiply(4'd9, 4'd0, tr, n);
    test_multiply(4'd1, 4'd8, tr, n);
    for (int i = 0; i < 6; i++)
      test_multiply(4'($urandom_range(15)), 4'($urandom_range(15)), tr, n);
  endtask

  task automatic test_reset_abort;
    cyc(1, 1, 1, 1, 1, 0, 4'hD, 4'hB);
    cyc(1, 0, 1, 0, 1, 1, 4'h0, 4'h0);
    #2 reset = 1'b0;
    #1;
    sb.push_back(mk(8'h00, 1'b0, 1'b1));
    e = sb.pop_front(); total++;
    if ({P, b0, z} !== {e.p, e.b0, e.z}) begin
      bad++;
      $display("FAIL reset_abort: got P=%h b0=%b z=%b want P=%h b0=%b z=%b", P, b0, z, e.p, e.b0, e.z);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_mul_5x3();
    test_mul_15x15();
    test_overflow();
    test_hold_clear();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
